// File: rtl/pop_sort_pkg.sv
// Shared types and helpers for the parametrised population sorter.
// Latency: n/a (types, constants and an elaboration-time function only).
// Backpressure: n/a.
package pop_sort_pkg;

    // Sorter control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SORT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Ordering modes for the compare/swap cells.
    localparam logic CMP_ASCENDING  = 1'b0;
    localparam logic CMP_DESCENDING = 1'b1;

    // Ceiling log2, used at elaboration to check the index width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pop_cmp_swap.sv
// Compare/swap cell: orders one adjacent (fit, idx) pair for the sort network.
// Latency: purely combinational, no state.
// Backpressure: none; outputs follow inputs.
// Ports: lo_*_i/hi_*_i = pair at slots (lo, hi); lo_*_o/hi_*_o = ordered pair;
//        swap_o = 1 when the pair was exchanged.
module pop_cmp_swap
    import pop_sort_pkg::*;
#(
    parameter int FIT_W      = 12,
    parameter int IDX_W      = 6,
    parameter bit DESCENDING = 1'b1
) (
    input  logic [FIT_W-1:0] lo_fit_i,
    input  logic [IDX_W-1:0] lo_idx_i,
    input  logic [FIT_W-1:0] hi_fit_i,
    input  logic [IDX_W-1:0] hi_idx_i,
    output logic [FIT_W-1:0] lo_fit_o,
    output logic [IDX_W-1:0] lo_idx_o,
    output logic [FIT_W-1:0] hi_fit_o,
    output logic [IDX_W-1:0] hi_idx_o,
    output logic             swap_o
);

    logic hi_ahead_fit;
    logic tie_hi_first;

    always_comb begin
        // Strictly better fitness in the high slot means it belongs lower.
        if (DESCENDING == CMP_DESCENDING) begin
            hi_ahead_fit = (hi_fit_i > lo_fit_i);
        end else begin
            hi_ahead_fit = (hi_fit_i < lo_fit_i);
        end
        // Equal fitness: lower population index goes first, keeping the order total.
        tie_hi_first = (hi_fit_i == lo_fit_i) && (hi_idx_i < lo_idx_i);
        swap_o       = hi_ahead_fit || tie_hi_first;

        if (swap_o) begin
            lo_fit_o = hi_fit_i;
            lo_idx_o = hi_idx_i;
            hi_fit_o = lo_fit_i;
            hi_idx_o = lo_idx_i;
        end else begin
            lo_fit_o = lo_fit_i;
            lo_idx_o = lo_idx_i;
            hi_fit_o = hi_fit_i;
            hi_idx_o = hi_idx_i;
        end
    end

endmodule

// File: rtl/pop_sorter_param.sv
// Population sorter: odd-even transposition sort of N (fitness, index) pairs, early exit when stable.
// Latency: start at edge k, P<=N phases at edges k+1..k+P, done pulse in the cycle after edge k+P+1.
// Backpressure: none; wr_en/start are dropped while busy, reads are always served with 1-cycle latency.
// Ports: wr_en/wr_addr/wr_fit load a slot (IDLE only); start kicks off a sort; busy/done report progress;
//        rd_addr selects a rank, rd_idx/rd_fit return it one cycle later; phases holds the last sort's phase count.
module pop_sorter_param
    import pop_sort_pkg::*;
#(
    parameter int N          = 50,
    parameter int FIT_W      = 12,
    parameter int IDX_W      = 6,
    parameter bit DESCENDING = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [FIT_W-1:0] wr_fit,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [IDX_W-1:0] rd_idx,
    output logic [FIT_W-1:0] rd_fit,
    output logic [IDX_W:0]   phases
);

    if (N < 1 || clog2(N) > IDX_W) begin : g_cfg_check
        $error("pop_sorter_param: N must be >= 1 and fit in IDX_W bits");
    end

    localparam logic [IDX_W:0] N_P   = (IDX_W+1)'(N);
    localparam logic [IDX_W:0] P_ONE = (IDX_W+1)'(1);
    localparam logic [IDX_W:0] P_TWO = (IDX_W+1)'(2);

    state_e state_q, state_d;

    logic [FIT_W-1:0] fit_q [N];
    logic [FIT_W-1:0] fit_d [N];
    logic [IDX_W-1:0] idx_q [N];
    logic [IDX_W-1:0] idx_d [N];

    logic [IDX_W:0]   p_q, p_d;
    logic             parity_q, parity_d;       // 0: even phase, 1: odd phase
    logic             prev_zero_q, prev_zero_d; // previous phase made no swaps
    logic [IDX_W:0]   phases_q, phases_d;
    logic             done_q, done_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [FIT_W-1:0] rd_fit_q, rd_fit_d;

    // Compare network: cell i orders slots (i, i+1). Even-numbered cells serve
    // even phases and odd-numbered cells serve odd phases; the last entry of
    // each array is a pass-through so the arrays stay N wide for any N.
    logic [FIT_W-1:0] lo_fit [N];
    logic [IDX_W-1:0] lo_idx [N];
    logic [FIT_W-1:0] hi_fit [N];
    logic [IDX_W-1:0] hi_idx [N];
    logic [N-1:0]     pair_swap;

    for (genvar i = 0; i < N; i++) begin : g_pair
        if (i < N - 1) begin : g_cmp
            pop_cmp_swap #(
                .FIT_W     (FIT_W),
                .IDX_W     (IDX_W),
                .DESCENDING(DESCENDING)
            ) u_cmp (
                .lo_fit_i(fit_q[i]),
                .lo_idx_i(idx_q[i]),
                .hi_fit_i(fit_q[i+1]),
                .hi_idx_i(idx_q[i+1]),
                .lo_fit_o(lo_fit[i]),
                .lo_idx_o(lo_idx[i]),
                .hi_fit_o(hi_fit[i]),
                .hi_idx_o(hi_idx[i]),
                .swap_o  (pair_swap[i])
            );
        end else begin : g_end
            assign lo_fit[i]    = fit_q[i];
            assign lo_idx[i]    = idx_q[i];
            assign hi_fit[i]    = fit_q[i];
            assign hi_idx[i]    = idx_q[i];
            assign pair_swap[i] = 1'b0;
        end
    end

    // Result of one phase at the current parity.
    logic [FIT_W-1:0] ph_fit [N];
    logic [IDX_W-1:0] ph_idx [N];
    logic             any_swap;

    always_comb begin
        ph_fit   = fit_q;
        ph_idx   = idx_q;
        any_swap = 1'b0;
        for (int s = 0; s < N; s++) begin
            if (1'(s) == parity_q) begin
                // Slot s is the low side of an active pair, unless it is the unpaired end.
                if (s < N - 1) begin
                    ph_fit[s] = lo_fit[s];
                    ph_idx[s] = lo_idx[s];
                    any_swap  = any_swap | pair_swap[s];
                end
            end else if (s > 0) begin
                // Slot s is the high side of the active pair starting at s-1.
                ph_fit[s] = hi_fit[(s > 0) ? s - 1 : 0];
                ph_idx[s] = hi_idx[(s > 0) ? s - 1 : 0];
            end
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        parity_d    = parity_q;
        prev_zero_d = prev_zero_q;
        phases_d    = phases_q;
        done_d      = 1'b0;
        fit_d       = fit_q;
        idx_d       = idx_q;

        case (state_q)
            ST_IDLE: begin
                // A write in the start cycle lands before the sort sees the data.
                if (wr_en) begin
                    for (int s = 0; s < N; s++) begin
                        if (wr_addr == IDX_W'(s)) begin
                            fit_d[s] = wr_fit;
                            idx_d[s] = IDX_W'(s);
                        end
                    end
                end
                if (start) begin
                    state_d     = ST_SORT;
                    p_d         = '0;
                    parity_d    = 1'b0;
                    prev_zero_d = 1'b0;
                end
            end
            ST_SORT: begin
                fit_d       = ph_fit;
                idx_d       = ph_idx;
                p_d         = p_q + P_ONE;
                parity_d    = ~parity_q;
                prev_zero_d = ~any_swap;
                // Two consecutive quiet phases cover every adjacent pair, so the order is final.
                if (p_d == N_P || (p_d >= P_TWO && !any_swap && prev_zero_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d   = 1'b1;
                phases_d = p_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered read port; addresses beyond the population read as zero.
    always_comb begin
        rd_idx_d = '0;
        rd_fit_d = '0;
        for (int s = 0; s < N; s++) begin
            if (rd_addr == IDX_W'(s)) begin
                rd_idx_d = idx_q[s];
                rd_fit_d = fit_q[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            p_q         <= '0;
            parity_q    <= 1'b0;
            prev_zero_q <= 1'b0;
            phases_q    <= '0;
            done_q      <= 1'b0;
            rd_idx_q    <= '0;
            rd_fit_q    <= '0;
            for (int s = 0; s < N; s++) begin
                fit_q[s] <= '0;
                idx_q[s] <= IDX_W'(s);
            end
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            parity_q    <= parity_d;
            prev_zero_q <= prev_zero_d;
            phases_q    <= phases_d;
            done_q      <= done_d;
            rd_idx_q    <= rd_idx_d;
            rd_fit_q    <= rd_fit_d;
            fit_q       <= fit_d;
            idx_q       <= idx_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign rd_idx = rd_idx_q;
    assign rd_fit = rd_fit_q;
    assign phases = phases_q;

endmodule

// File: tb/tb_pop_sorter_param.sv
// Bench for pop_sorter_param: five instances (N=50/8/8/7/1, both orders) share one stimulus stream.
// Latency: checks done timing, phase counts and the registered read port against a reference model.
// Backpressure: exercises writes/starts while busy and a reset in the middle of a sort.
module tb_pop_sorter_param;

    localparam int ND = 5;
    localparam int FW = 12;
    localparam int IW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          wr_en;
    logic [IW-1:0] wr_addr;
    logic [FW-1:0] wr_fit;
    logic          start;
    logic [IW-1:0] rd_addr;

    logic [ND-1:0] busy_v;
    logic [ND-1:0] done_v;
    logic [IW-1:0] rd_idx_v [ND];
    logic [FW-1:0] rd_fit_v [ND];
    logic [IW:0]   phases_v [ND];

    pop_sorter_param #(.N(50), .FIT_W(FW), .IDX_W(IW), .DESCENDING(1'b1)) u_d0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_fit(wr_fit),
        .start(start), .busy(busy_v[0]), .done(done_v[0]), .rd_addr(rd_addr),
        .rd_idx(rd_idx_v[0]), .rd_fit(rd_fit_v[0]), .phases(phases_v[0]));
    pop_sorter_param #(.N(8), .FIT_W(FW), .IDX_W(IW), .DESCENDING(1'b1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_fit(wr_fit),
        .start(start), .busy(busy_v[1]), .done(done_v[1]), .rd_addr(rd_addr),
        .rd_idx(rd_idx_v[1]), .rd_fit(rd_fit_v[1]), .phases(phases_v[1]));
    pop_sorter_param #(.N(8), .FIT_W(FW), .IDX_W(IW), .DESCENDING(1'b0)) u_d2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_fit(wr_fit),
        .start(start), .busy(busy_v[2]), .done(done_v[2]), .rd_addr(rd_addr),
        .rd_idx(rd_idx_v[2]), .rd_fit(rd_fit_v[2]), .phases(phases_v[2]));
    pop_sorter_param #(.N(7), .FIT_W(FW), .IDX_W(IW), .DESCENDING(1'b1)) u_d3 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_fit(wr_fit),
        .start(start), .busy(busy_v[3]), .done(done_v[3]), .rd_addr(rd_addr),
        .rd_idx(rd_idx_v[3]), .rd_fit(rd_fit_v[3]), .phases(phases_v[3]));
    pop_sorter_param #(.N(1), .FIT_W(FW), .IDX_W(IW), .DESCENDING(1'b0)) u_d4 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_fit(wr_fit),
        .start(start), .busy(busy_v[4]), .done(done_v[4]), .rd_addr(rd_addr),
        .rd_idx(rd_idx_v[4]), .rd_fit(rd_fit_v[4]), .phases(phases_v[4]));

    int total = 0;
    int bad   = 0;

    // Reference model state per instance.
    int m_fit [ND][64];
    int m_idx [ND][64];
    int exp_p [ND];
    int dcnt  [ND];
    int dcyc  [ND];
    int bbad  [ND];
    int tp2   [8] = '{1, 3, 7, 5, 0, 6, 2, 4};

    function automatic int n_of(input int d);
        case (d)
            0:       return 50;
            1:       return 8;
            2:       return 8;
            3:       return 7;
            default: return 1;
        endcase
    endfunction

    function automatic bit desc_of(input int d);
        return (d == 0 || d == 1 || d == 3);
    endfunction

    // True when entry a belongs ahead of entry b in the final order.
    function automatic bit ahead(input bit desc, input int fa, input int ia, input int fb, input int ib);
        if (fa != fb) return desc ? (fa > fb) : (fa < fb);
        return ia < ib;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic model_reset;
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < 64; i++) begin
                m_fit[d][i] = 0;
                m_idx[d][i] = i;
            end
        end
    endtask

    task automatic model_write(input int a, input int f);
        for (int d = 0; d < ND; d++) begin
            if (a < n_of(d)) begin
                m_fit[d][a] = f;
                m_idx[d][a] = a;
            end
        end
    endtask

    // Final order from ranks; phase count from replaying the transposition rules.
    task automatic model_sort(input int d);
        int n, r, p, swaps, t;
        int sf [64];
        int si [64];
        int wf [64];
        int wi [64];
        bit desc, prev_zero, stop;
        n = n_of(d);
        desc = desc_of(d);
        for (int j = 0; j < n; j++) begin
            r = 0;
            for (int k = 0; k < n; k++) begin
                if (ahead(desc, m_fit[d][k], m_idx[d][k], m_fit[d][j], m_idx[d][j])) r++;
            end
            sf[r] = m_fit[d][j];
            si[r] = m_idx[d][j];
            wf[j] = m_fit[d][j];
            wi[j] = m_idx[d][j];
        end
        p = 0;
        prev_zero = 1'b0;
        stop = 1'b0;
        while (!stop) begin
            p++;
            swaps = 0;
            for (int lo = (p - 1) % 2; lo + 1 < n; lo += 2) begin
                if (ahead(desc, wf[lo+1], wi[lo+1], wf[lo], wi[lo])) begin
                    t = wf[lo]; wf[lo] = wf[lo+1]; wf[lo+1] = t;
                    t = wi[lo]; wi[lo] = wi[lo+1]; wi[lo+1] = t;
                    swaps++;
                end
            end
            if (p == n || (p >= 2 && swaps == 0 && prev_zero)) stop = 1'b1;
            prev_zero = (swaps == 0);
        end
        exp_p[d] = p;
        for (int j = 0; j < n; j++) begin
            m_fit[d][j] = sf[j];
            m_idx[d][j] = si[j];
        end
    endtask

    task automatic write_slot(input int a, input int f);
        wr_en   = 1'b1;
        wr_addr = IW'(a);
        wr_fit  = FW'(f);
        model_write(a, f);
        tick;
        wr_en = 1'b0;
    endtask

    task automatic read_all(input string tag);
        int ei, ef;
        for (int a = 0; a < 50; a++) begin
            rd_addr = IW'(a);
            tick;
            for (int d = 0; d < ND; d++) begin
                ei = (a < n_of(d)) ? m_idx[d][a] : 0;
                ef = (a < n_of(d)) ? m_fit[d][a] : 0;
                chk($sformatf("%s rd_idx d%0d r%0d", tag, d, a), int'(rd_idx_v[d]), ei);
                chk($sformatf("%s rd_fit d%0d r%0d", tag, d, a), int'(rd_fit_v[d]), ef);
            end
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        wr_en = 1'b0;
        start = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        model_reset();
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("reset busy d%0d", d), int'(busy_v[d]), 0);
            chk($sformatf("reset done d%0d", d), int'(done_v[d]), 0);
            chk($sformatf("reset phases d%0d", d), int'(phases_v[d]), 0);
        end
    endtask

    // Starts a sort (optionally with a same-cycle write), optionally pokes
    // wr_en/start while busy, optionally resets at SORT cycle abort_c.
    task automatic run_sort(input string tag, input bit with_wr, input int wa, input int wf,
                            input bit inject, input int abort_c);
        bit aborted;
        aborted = 1'b0;
        if (with_wr) begin
            wr_en   = 1'b1;
            wr_addr = IW'(wa);
            wr_fit  = FW'(wf);
            model_write(wa, wf);
        end
        start = 1'b1;
        for (int d = 0; d < ND; d++) model_sort(d);
        tick;
        wr_en = 1'b0;
        start = 1'b0;
        for (int d = 0; d < ND; d++) begin
            dcnt[d] = 0;
            dcyc[d] = -1;
            bbad[d] = (busy_v[d] !== 1'b1) ? 1 : 0;
        end
        if (inject) begin
            wr_en   = 1'b1;
            wr_addr = IW'($urandom_range(0, 7));
            wr_fit  = FW'($urandom);
            start   = 1'b1;
        end
        for (int c = 1; c <= 60 && !aborted; c++) begin
            tick;
            wr_en = 1'b0;
            start = 1'b0;
            for (int d = 0; d < ND; d++) begin
                if (done_v[d]) begin
                    dcnt[d]++;
                    if (dcyc[d] < 0) dcyc[d] = c;
                end
                if (busy_v[d] !== (c <= exp_p[d])) bbad[d]++;
            end
            if (c == abort_c) begin
                rst_n = 1'b0;
                tick;
                if (done_v[0]) dcnt[0]++;
                tick;
                if (done_v[0]) dcnt[0]++;
                rst_n = 1'b1;
                model_reset();
                aborted = 1'b1;
            end
        end
        for (int d = 0; d < ND; d++) begin
            if (aborted && d == 0) begin
                chk({tag, " d0 no done after abort"}, dcnt[0], 0);
                chk({tag, " d0 busy before abort"}, bbad[0], 0);
                chk({tag, " d0 busy after abort"}, int'(busy_v[0]), 0);
                chk({tag, " d0 phases after abort"}, int'(phases_v[0]), 0);
            end else begin
                chk($sformatf("%s done count d%0d", tag, d), dcnt[d], 1);
                chk($sformatf("%s done cycle d%0d", tag, d), dcyc[d], exp_p[d] + 1);
                chk($sformatf("%s busy shape d%0d", tag, d), bbad[d], 0);
                if (!aborted) chk($sformatf("%s phases d%0d", tag, d), int'(phases_v[d]), exp_p[d]);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_fit  = '0;
        start   = 1'b0;
        rd_addr = '0;

        do_reset();
        read_all("reset");

        // Mixed data with a 7/7 tie; last slot written in the start cycle.
        write_slot(0, 3); write_slot(1, 7); write_slot(2, 1); write_slot(3, 7);
        write_slot(4, 0); write_slot(5, 5); write_slot(6, 2);
        run_sort("mixed", 1'b1, 7, 6, 1'b0, 0);
        read_all("mixed");
        for (int r = 0; r < 8; r++) begin
            rd_addr = IW'(r);
            tick;
            chk($sformatf("mixed d1 rank %0d", r), int'(rd_idx_v[1]), tp2[r]);
        end

        // Already in descending order: two quiet phases.
        for (int a = 0; a < 8; a++) write_slot(a, 9 - a);
        run_sort("presort", 1'b0, 0, 0, 1'b0, 0);
        chk("presort d1 phases", int'(phases_v[1]), 2);
        chk("presort d1 done cycle", dcyc[1], 3);
        read_all("presort");

        // Reverse data for the ascending instance: worst case.
        for (int a = 0; a < 8; a++) write_slot(a, 7 - a);
        run_sort("reverse", 1'b0, 0, 0, 1'b0, 0);
        chk("reverse d2 phases", int'(phases_v[2]), 8);
        for (int r = 0; r < 8; r++) begin
            rd_addr = IW'(r);
            tick;
            chk($sformatf("reverse d2 rank %0d", r), int'(rd_idx_v[2]), 7 - r);
        end
        read_all("reverse");

        // Random data with the minimum at slot 0 so the big sort is still running when reset hits.
        for (int a = 0; a < 50; a++) write_slot(a, (a == 0) ? 0 : int'($urandom_range(1, 4095)));
        run_sort("abort", 1'b0, 0, 0, 1'b0, 9);
        read_all("abort");

        // Reload with many ties, poke wr_en/start while busy.
        for (int a = 0; a < 50; a++) write_slot(a, int'($urandom_range(0, 15)));
        run_sort("ties", 1'b0, 0, 0, 1'b1, 0);
        read_all("ties");

        // Full-range random round with a same-cycle write.
        for (int a = 0; a < 50; a++) write_slot(a, int'($urandom_range(0, 4095)));
        run_sort("random", 1'b1, 3, int'($urandom_range(0, 4095)), 1'b1, 0);
        read_all("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
